mem_lsu: RTL and testbench

Load/store unit placed directly upstream of the single-port data RAM (256 × 32-bit words, 8-bit word address, combinational read, write on rising clock edge when `we` is high). It takes byte-addressed load/store requests from the core through a valid/ready handshake. It performs byte and halfword stores as read-modify-write sequences and sign- or zero-extends sub-word loads. It rejects misaligned or reserved-size accesses without touching the RAM.

---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_lsu_align.sv | 24 ++
 rtl/mem_lsu.sv | 84 ++++++++
 tb/tb_mem_lsu.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared LSU size encodings, FSM states and default address width
package mem_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, LD, ST_RD, ST_WR, RSP} state_e;
endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: little-endian lane extract/extend for loads and lane merge for stores
module mem_lsu_align import mem_pkg::*; (
  input  logic [31:0] rdata_i,
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ld_o,
  output logic [31:0] wr_o
);
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;
  always_comb begin
    sh   = size_i == SZ_HALF ? {off_i[1], 4'b0} : {off_i, 3'b0};
    lane = 16'(rdata_i >> sh);
    ld_o = size_i == SZ_BYTE ? {{24{~uns_i & lane[7]}}, lane[7:0]} :
           size_i == SZ_HALF ? {{16{~uns_i & lane[15]}}, lane} : rdata_i;
    mask = size_i == SZ_BYTE ? 32'h0000_00FF << sh :
           size_i == SZ_HALF ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    wr_o = (old_i & ~mask) | ((new_i << sh) & mask);
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit with RMW sub-word stores in front of a single-port word RAM
module mem_lsu import mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q, merge_q, rdata_q;
  logic              err_q;
  logic              err;
  logic [31:0]       ld_val, wr_val;
  assign err = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0]) ||
               (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign state_d = err ? RSP : !req_we ? LD : req_size == SZ_WORD ? ST_WR : ST_RD;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RSP;
  assign ram_we    = state_q == ST_WR;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = ram_we ? wr_val : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  mem_lsu_align u_align (
    .rdata_i (ram_rdata),
    .old_i   (merge_q),
    .new_i   (wdata_q),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .ld_o    (ld_val),
    .wr_o    (wr_val)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          wdata_q <= req_wdata;
          err_q   <= err;
          if (err || req_we) rdata_q <= '0;
          state_q <= state_d;
        end
        LD: begin
          rdata_q <= ld_val;
          state_q <= RSP;
        end
        ST_RD: begin
          merge_q <= ram_rdata;
          state_q <= ST_WR;
        end
        ST_WR:   state_q <= RSP;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu against a behavioural 256x32 RAM
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;
  int lat, we_cnt, we_lat;
  logic [31:0] got_rdata;
  logic        got_err;

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  mem_lsu #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // one request: drive, accept, then watch up to 8 cycles for the response
  task automatic xfer(input logic we, input logic [9:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we_cnt = 0; we_lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ram_we) begin we_cnt++; we_lat = c; end
      if (rsp_valid) begin
        lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    int acc, rcnt, last_acc, cyc;
    logic rdy;
    logic [31:0] exp_q [3];
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    #20 rst_n = 1'b1;

    xfer(1'b1, 10'h010, 2'b10, 1'b0, 32'hDEAD_BEEF);
    chk("sw_latency", lat, 2);
    chk("sw_err", 32'(got_err), 32'd0);
    chk("sw_rdata", got_rdata, 32'd0);
    chk("sw_ram_word4", mem[4], 32'hDEAD_BEEF);

    xfer(1'b0, 10'h010, 2'b10, 1'b0, 32'h0);
    chk("lw_latency", lat, 2);
    chk("lw_rdata", got_rdata, 32'hDEAD_BEEF);
    chk("lw_no_write", we_cnt, 0);

    xfer(1'b1, 10'h012, 2'b00, 1'b0, 32'h0000_0055);
    chk("sb_latency", lat, 3);
    chk("sb_we_count", we_cnt, 1);
    chk("sb_we_cycle", we_lat, 2);
    chk("sb_ram_word4", mem[4], 32'hDE55_BEEF);

    xfer(1'b0, 10'h013, 2'b00, 1'b0, 32'h0);
    chk("lb_signed", got_rdata, 32'hFFFF_FFDE);
    xfer(1'b0, 10'h013, 2'b00, 1'b1, 32'h0);
    chk("lbu_unsigned", got_rdata, 32'h0000_00DE);
    xfer(1'b0, 10'h010, 2'b01, 1'b0, 32'h0);
    chk("lh_signed", got_rdata, 32'hFFFF_BEEF);
    xfer(1'b0, 10'h012, 2'b01, 1'b1, 32'h0);
    chk("lhu_upper", got_rdata, 32'h0000_DE55);

    xfer(1'b0, 10'h011, 2'b10, 1'b0, 32'h0);
    chk("lw_mis_err", 32'(got_err), 32'd1);
    chk("lw_mis_rdata", got_rdata, 32'd0);
    chk("lw_mis_latency", lat, 1);
    chk("lw_mis_no_we", we_cnt, 0);
    xfer(1'b1, 10'h013, 2'b01, 1'b0, 32'h0000_1234);
    chk("sh_mis_err", 32'(got_err), 32'd1);
    chk("sh_mis_latency", lat, 1);
    chk("sh_mis_no_we", we_cnt, 0);
    chk("sh_mis_word4", mem[4], 32'hDE55_BEEF);
    xfer(1'b0, 10'h010, 2'b11, 1'b0, 32'h0);
    chk("reserved_size_err", 32'(got_err), 32'd1);
    xfer(1'b1, 10'h012, 2'b01, 1'b0, 32'h0000_CAFE);
    chk("sh_ok_err", 32'(got_err), 32'd0);
    chk("sh_ok_word4", mem[4], 32'hCAFE_BEEF);

    // reset while the RMW sits in ST_RD
    @(negedge clk);
    req_we = 1'b1; req_addr = 10'h011; req_size = 2'b00; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("mid_rst_ram_wdata", ram_wdata, 32'd0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_word4", mem[4], 32'hCAFE_BEEF);

    xfer(1'b1, 10'h004, 2'b10, 1'b0, 32'h1111_0001);
    xfer(1'b1, 10'h008, 2'b10, 1'b0, 32'h2222_0002);
    xfer(1'b1, 10'h00C, 2'b10, 1'b0, 32'h3333_0003);
    exp_q[0] = 32'h1111_0001; exp_q[1] = 32'h2222_0002; exp_q[2] = 32'h3333_0003;

    // three queued loads with req_valid held high
    @(negedge clk);
    acc = 0; rcnt = 0; last_acc = -10;
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 10'h004; req_valid = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (rsp_valid) begin
        chk("queue_rsp_ready_low", 32'(req_ready), 32'd0);
        if (rcnt < 3) chk("queue_rsp_data", rsp_rdata, exp_q[rcnt]);
        rcnt++;
      end
      rdy = req_ready;
      @(posedge clk);
      if (rdy && req_valid) begin
        if (acc > 0) chk("queue_issue_gap", cyc - last_acc, 3);
        last_acc = cyc;
        acc++;
        #1;
        if (acc == 3) req_valid = 1'b0;
        else req_addr = 10'(req_addr + 10'd4);
      end
      @(negedge clk);
    end
    chk("queue_accepts", acc, 3);
    chk("queue_responses", rcnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
